// File: rtl/reg_dump_pkg.sv
// ==== reg_dump_pkg : shared state encoding and framing constants for reg_dump (rev 1.0) ====
`default_nettype none

package reg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CAP   = 3'd1,
    ST_SEND  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  localparam logic [2:0] HDR_TAG       = 3'b101;
  localparam int         BYTES_PER_REG = 5;

  // sel 0 is the most significant byte, matching the wire order of the payload.
  function automatic logic [7:0] data_byte(input logic [31:0] word, input logic [1:0] sel);
    logic [7:0] b;
    b = 8'h00;
    case (sel)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_dump.sv
// ==== reg_dump : walks the register file and emits header+4 data bytes per register, then an XOR checksum (rev 1.0) ====
`default_nettype none

module reg_dump #(
  parameter int         NUM_REGS = 18,
  parameter logic [2:0] HDR_TAG  = reg_dump_pkg::HDR_TAG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  readReg,
  input  logic [31:0] readData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  import reg_dump_pkg::*;

  if (NUM_REGS < 1 || NUM_REGS > 32) begin : g_bad_num_regs
    $error("reg_dump: NUM_REGS must be in 1..32");
  end

  localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);
  localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_REG - 1);

  state_t      state, state_n;
  logic [4:0]  idx, idx_n;
  logic [2:0]  byte_cnt, byte_cnt_n;
  logic [7:0]  checksum, checksum_n;
  logic [31:0] snap, snap_n;
  logic [7:0]  tx_data_n;
  logic        tx_valid_n;
  logic        handshake;

  assign handshake = tx_valid && tx_ready;
  assign readReg   = idx;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= 5'd0;
      byte_cnt <= 3'd0;
      checksum <= 8'h00;
      snap     <= 32'h0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      byte_cnt <= byte_cnt_n;
      checksum <= checksum_n;
      snap     <= snap_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    byte_cnt_n = byte_cnt;
    checksum_n = checksum;
    snap_n     = snap;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;

    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_n      = 5'd0;
          checksum_n = 8'h00;
          state_n    = ST_CAP;
        end
      end

      ST_CAP: begin
        snap_n     = readData;
        tx_data_n  = {HDR_TAG, idx};
        byte_cnt_n = 3'd0;
        tx_valid_n = 1'b1;
        state_n    = ST_SEND;
      end

      ST_SEND: begin
        if (handshake) begin
          checksum_n = checksum ^ tx_data;
          if (byte_cnt == LAST_BYTE) begin
            if (idx == LAST_IDX) begin
              // Trailer goes out back-to-back, so it must include the byte just accepted.
              tx_data_n = checksum ^ tx_data;
              state_n   = ST_TRAIL;
            end else begin
              idx_n      = idx + 5'd1;
              tx_valid_n = 1'b0;
              state_n    = ST_CAP;
            end
          end else begin
            tx_data_n  = data_byte(snap, byte_cnt[1:0]);
            byte_cnt_n = byte_cnt + 3'd1;
          end
        end
      end

      ST_TRAIL: begin
        if (handshake) begin
          tx_valid_n = 1'b0;
          state_n    = ST_FIN;
        end
      end

      ST_FIN: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n    = ST_IDLE;
        tx_valid_n = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
